// File: rtl/axis_packet_arbiter_if.sv
// AXI-Stream bundle carrying N_LANES parallel streams; the arbiter uses one
// multi-lane instance on its source side and a single-lane instance on its output.
interface axis_packet_arbiter_if #(
    parameter int N_LANES   = 1,
    parameter int BUS_WIDTH = 64,
    parameter int KEEP_W    = 8
);
    logic [N_LANES-1:0]           valid;
    logic [N_LANES-1:0]           ready;
    logic [N_LANES-1:0]           last;
    logic [N_LANES*BUS_WIDTH-1:0] data;
    logic [N_LANES*KEEP_W-1:0]    keep;

    modport master (output valid, output last, output data, output keep, input  ready);
    modport slave  (input  valid, input  last, input  data, input  keep, output ready);
endinterface

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter: N_SRC AXI-Stream sources share one output,
// a grant lasts until the granted source's last beat is accepted.
module axis_packet_arbiter #(
    parameter int N_SRC          = 4,
    parameter int WORD_WIDTH     = 8,
    parameter int BUS_WIDTH      = 64,
    parameter int WORDS_PER_BEAT = BUS_WIDTH / WORD_WIDTH,
    parameter int ID_W           = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    parameter int CNT_W          = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    axis_packet_arbiter_if.slave  s,
    axis_packet_arbiter_if.master m,
    output logic [ID_W-1:0]       m_id,
    output logic [CNT_W-1:0]      pkt_count
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state_q,     state_d;
    logic [ID_W-1:0]  grant_q,     grant_d;
    logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;

    logic                      busy;
    logic [N_SRC-1:0]          sel;
    logic                      req_found;
    logic [ID_W-1:0]           req_idx;
    int                        req_pos;
    logic                      out_valid;
    logic                      out_last;
    logic [BUS_WIDTH-1:0]      out_data;
    logic [WORDS_PER_BEAT-1:0] out_keep;
    logic                      last_accepted;

    assign busy = (state_q == BUSY);

    // Only the granted lane ever sees m_ready; every other source is held off.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_lane
            assign sel[gi]     = busy && (grant_q == ID_W'(gi));
            assign s.ready[gi] = sel[gi] & m.ready[0];
        end
    endgenerate

    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        out_keep  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (sel[k]) begin
                out_valid = s.valid[k];
                out_last  = s.last[k];
                out_data  = s.data[k*BUS_WIDTH +: BUS_WIDTH];
                out_keep  = s.keep[k*WORDS_PER_BEAT +: WORDS_PER_BEAT];
            end
        end
    end

    assign m.valid   = out_valid;
    assign m.last    = out_last;
    assign m.data    = out_data;
    assign m.keep    = out_keep;
    assign m_id      = grant_q;
    assign pkt_count = pkt_count_q;

    // Scan from the highest offset down so the nearest requester after rr_ptr wins.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        req_pos   = 0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            req_pos = (int'(rr_ptr_q) + i) % N_SRC;
            if (s.valid[req_pos]) begin
                req_found = 1'b1;
                req_idx   = ID_W'(req_pos);
            end
        end
    end

    assign last_accepted = out_valid & m.ready[0] & out_last;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    grant_d = req_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last_accepted) begin
                    state_d     = IDLE;
                    rr_ptr_d    = (grant_q == ID_W'(N_SRC - 1)) ? '0 : grant_q + ID_W'(1);
                    pkt_count_d = pkt_count_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            pkt_count_q <= pkt_count_d;
        end
    end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: a 4-source instance plus a
// 1-source, 2-bit-counter instance for the degenerate and wrap cases.
module tb_axis_packet_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_packet_arbiter_if #(.N_LANES(4), .BUS_WIDTH(64), .KEEP_W(8)) src_if ();
    axis_packet_arbiter_if #(.N_LANES(1), .BUS_WIDTH(64), .KEEP_W(8)) out_if ();
    axis_packet_arbiter_if #(.N_LANES(1), .BUS_WIDTH(64), .KEEP_W(8)) src1_if ();
    axis_packet_arbiter_if #(.N_LANES(1), .BUS_WIDTH(64), .KEEP_W(8)) out1_if ();

    logic [3:0]  sv, sl;
    logic [63:0] sd [4];
    logic [7:0]  sk [4];
    logic        mr;
    logic [1:0]  m_id;
    logic [15:0] pkt_count;

    logic        sv1, sl1, mr1;
    logic [63:0] sd1;
    logic [0:0]  m_id1;
    logic [1:0]  pkt_count1;

    assign src_if.valid = sv;
    assign src_if.last  = sl;
    assign out_if.ready = mr;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_src
            assign src_if.data[gi*64 +: 64] = sd[gi];
            assign src_if.keep[gi*8 +: 8]   = sk[gi];
        end
    endgenerate

    assign src1_if.valid = sv1;
    assign src1_if.last  = sl1;
    assign src1_if.data  = sd1;
    assign src1_if.keep  = 8'hFF;
    assign out1_if.ready = mr1;

    axis_packet_arbiter #(.N_SRC(4), .WORD_WIDTH(8), .BUS_WIDTH(64), .CNT_W(16)) u_dut (
        .aclk(clk), .areset(rst), .s(src_if), .m(out_if), .m_id(m_id), .pkt_count(pkt_count)
    );

    axis_packet_arbiter #(.N_SRC(1), .WORD_WIDTH(8), .BUS_WIDTH(64), .CNT_W(2)) u_dut1 (
        .aclk(clk), .areset(rst), .s(src1_if), .m(out1_if), .m_id(m_id1), .pkt_count(pkt_count1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        sv = '0; sl = '0; mr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sd[k] = '0;
            sk[k] = '0;
        end
        sv1 = 1'b0; sl1 = 1'b0; sd1 = '0; mr1 = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_sready"}, 64'(src_if.ready), 64'(0));
        check_val({tag, "_mvalid"}, 64'(out_if.valid), 64'(0));
        check_val({tag, "_mlast"},  64'(out_if.last),  64'(0));
        check_val({tag, "_mdata"},  out_if.data,       64'(0));
        check_val({tag, "_mkeep"},  64'(out_if.keep),  64'(0));
        check_val({tag, "_mid"},    64'(m_id),         64'(0));
        check_val({tag, "_count"},  64'(pkt_count),    64'(0));
    endtask

    // One line per completed output packet.
    always @(negedge clk) begin
        if (!rst && out_if.valid[0] && out_if.ready[0] && out_if.last[0])
            $display("packet done: src=%0d count_before=%0d", m_id, pkt_count);
        if (!rst && out1_if.valid[0] && out1_if.ready[0] && out1_if.last[0])
            $display("packet done (1-src): count_before=%0d", pkt_count1);
    end

    int          beat [4];
    logic [3:0]  hs;
    int          tx [4], rx [4], nb [4];
    logic [63:0] bd [4][64];
    logic [7:0]  bk [4][64];
    logic        bl [4][64];
    int          pkts, id, len, cyc;
    logic [7:0]  kp;
    int          exp_cnt [5] = '{1, 2, 3, 0, 1};

    initial begin
        idle_all();
        // Reset with every source requesting: nothing may leak through.
        sv = 4'hF;
        tick();
        tick();
        check_all_zero("reset");
        sv = '0;
        rst = 1'b0;

        // Source 2, three-beat packet.
        tick();
        sv[2] = 1'b1; sd[2] = 64'h10; sk[2] = 8'hFF; sl[2] = 1'b0; mr = 1'b1;
        #1;
        check_val("t1_idle_mvalid", 64'(out_if.valid), 64'(0));
        check_val("t1_idle_sready", 64'(src_if.ready), 64'(0));
        for (int b = 0; b < 3; b++) begin
            tick();
            sd[2] = 64'(16 + b);
            sl[2] = (b == 2);
            #1;
            check_val("t1_mvalid", 64'(out_if.valid), 64'(1));
            check_val("t1_mdata",  out_if.data,       64'(16 + b));
            check_val("t1_mid",    64'(m_id),         64'(2));
            check_val("t1_sready", 64'(src_if.ready), 64'(4'b0100));
            check_val("t1_mlast",  64'(out_if.last),  64'(b == 2));
        end
        tick();
        sv = '0; sl = '0;
        #1;
        check_val("t1_after_mvalid", 64'(out_if.valid), 64'(0));
        check_val("t1_after_count",  64'(pkt_count),    64'(1));

        // All four sources continuously offering two-beat packets.
        apply_reset();
        mr = 1'b1;
        for (int k = 0; k < 4; k++) beat[k] = 0;
        for (int c = 0; c < 24; c++) begin
            for (int k = 0; k < 4; k++) begin
                sv[k] = 1'b1;
                sd[k] = 64'(k * 16 + beat[k]);
                sl[k] = (beat[k] == 1);
                sk[k] = 8'hFF;
            end
            #1;
            if (c % 3 == 0) begin
                check_val("t2_bubble", 64'(out_if.valid), 64'(0));
            end else begin
                check_val("t2_mvalid", 64'(out_if.valid), 64'(1));
                check_val("t2_mid",    64'(m_id),         64'((c / 3) % 4));
                check_val("t2_mdata",  out_if.data,       64'(((c / 3) % 4) * 16 + (c % 3) - 1));
                check_val("t2_mlast",  64'(out_if.last),  64'(c % 3 == 2));
            end
            hs = src_if.ready & sv;
            tick();
            for (int k = 0; k < 4; k++) if (hs[k]) beat[k] = beat[k] ^ 1;
        end
        check_val("t2_count", 64'(pkt_count), 64'(8));
        sv = '0; sl = '0;

        // Source 1 stalls mid-packet while source 0 requests.
        sv[1] = 1'b1; sd[1] = 64'h21; sl[1] = 1'b0;
        #1;
        check_val("t3_idle", 64'(out_if.valid), 64'(0));
        tick();
        #1;
        check_val("t3_mid",   64'(m_id),   64'(1));
        check_val("t3_mdata", out_if.data, 64'h21);
        tick();
        sv[1] = 1'b0;
        sv[0] = 1'b1; sd[0] = 64'h01; sl[0] = 1'b1; sk[0] = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("t3_stall_mvalid", 64'(out_if.valid), 64'(0));
            check_val("t3_stall_mid",    64'(m_id),         64'(1));
            check_val("t3_stall_sready", 64'(src_if.ready), 64'(4'b0010));
            tick();
        end
        sv[1] = 1'b1; sd[1] = 64'h22; sl[1] = 1'b1;
        #1;
        check_val("t3_last_mdata", out_if.data,      64'h22);
        check_val("t3_last_mlast", 64'(out_if.last), 64'(1));
        tick();
        sv[1] = 1'b0; sl[1] = 1'b0;
        #1;
        check_val("t3_bubble", 64'(out_if.valid), 64'(0));
        tick();
        #1;
        check_val("t3_next_mid",   64'(m_id),   64'(0));
        check_val("t3_next_mdata", out_if.data, 64'h01);
        tick();
        sv = '0; sl = '0;

        // Randomized stalls, 40 ramp packets (10 per source) with partial last-beat keep.
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            nb[k] = 0; tx[k] = 0; rx[k] = 0;
            for (int p = 0; p < 10; p++) begin
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++) begin
                    kp = 8'hFF >> $urandom_range(0, 7);
                    bd[k][nb[k]] = (64'(k) << 32) | 64'(nb[k]);
                    bl[k][nb[k]] = (b == len - 1);
                    bk[k][nb[k]] = (b == len - 1) ? kp : 8'hFF;
                    nb[k]++;
                end
            end
        end
        pkts = 0;
        cyc  = 0;
        while (pkts < 40 && cyc < 5000) begin
            for (int k = 0; k < 4; k++) begin
                if (tx[k] < nb[k]) begin
                    sv[k] = ($urandom_range(0, 99) >= 5);
                    sd[k] = bd[k][tx[k]];
                    sk[k] = bk[k][tx[k]];
                    sl[k] = bl[k][tx[k]];
                end else begin
                    sv[k] = 1'b0; sd[k] = '0; sk[k] = '0; sl[k] = 1'b0;
                end
            end
            mr = ($urandom_range(0, 99) >= 20);
            #1;
            hs = src_if.ready & sv;
            if (out_if.valid[0] && mr) begin
                id = int'(m_id);
                if (rx[id] < nb[id]) begin
                    check_val("t4_mdata", out_if.data,      bd[id][rx[id]]);
                    check_val("t4_mkeep", 64'(out_if.keep), 64'(bk[id][rx[id]]));
                    check_val("t4_mlast", 64'(out_if.last), 64'(bl[id][rx[id]]));
                    if (out_if.last[0]) pkts++;
                    rx[id]++;
                end else begin
                    check_val("t4_overrun", 64'(rx[id]), 64'(nb[id] - 1));
                end
            end
            tick();
            for (int k = 0; k < 4; k++) if (hs[k]) tx[k]++;
            cyc++;
        end
        check_val("t4_packets", 64'(pkts),      64'(40));
        check_val("t4_count",   64'(pkt_count), 64'(40));
        for (int k = 0; k < 4; k++) check_val("t4_beats", 64'(rx[k]), 64'(nb[k]));
        sv = '0; sl = '0; mr = 1'b1;

        // Asynchronous reset while source 3 is on beat 2 of 4.
        tick();
        sv[3] = 1'b1; sd[3] = 64'h30; sk[3] = 8'hFF; sl[3] = 1'b0;
        tick();
        tick();
        sd[3] = 64'h31;
        #1;
        check_val("t5_pre_mdata", out_if.data, 64'h31);
        sv[1] = 1'b1; sd[1] = 64'h41; sk[1] = 8'hFF; sl[1] = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("t5_async");
        tick();
        rst = 1'b0;
        sd[3] = 64'h30;
        #1;
        check_val("t5_post_idle", 64'(out_if.valid), 64'(0));
        tick();
        #1;
        check_val("t5_post_mid",   64'(m_id),   64'(1));
        check_val("t5_post_mdata", out_if.data, 64'h41);
        sv = '0; sl = '0;

        // Single-source instance: 1-cycle bubble per packet, 2-bit counter wrap.
        tick();
        sv1 = 1'b1; sl1 = 1'b1; mr1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sd1 = 64'(8'hA0 + i);
            #1;
            check_val("t6_bubble", 64'(out1_if.valid), 64'(0));
            tick();
            #1;
            check_val("t6_mvalid", 64'(out1_if.valid), 64'(1));
            check_val("t6_mdata",  out1_if.data,       64'(8'hA0 + i));
            check_val("t6_mid",    64'(m_id1),         64'(0));
            tick();
            check_val("t6_count",  64'(pkt_count1),    64'(exp_cnt[i]));
        end
        idle_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
